cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Parametrised run/step controller for the basic CPU core. It replaces hand-toggled clocking with a single free-running clock plus a registered clock-enable (cpu_en). It also drives a stretched CPU reset (cpu_rst). It sits between the board/test harness and cpu_ctrl, and supports free-run, N-cycle burst and single-step modes. A saturating executed-cycle counter is provided for debug.

Parameters:
CNT_W, 16, width of cycle_cnt
BURST_W, 8, width of burst_len and the internal remaining-cycles counter
RST_CYCLES, 4, clk edges cpu_rst stays high after rst deasserts (min 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mode  in  2  00 free-run, 01 burst, 10 single-step, 11 reserved
start  in  1  level, sampled in IDLE only; begins the selected mode
step  in  1  step request; each 0->1 transition gives one enable cycle (step mode only)
halt  in  1  stop request; priority over start/step
burst_len  in  BURST_W  cycles to run in burst mode, sampled with start
cpu_rst  out  1  reset to cpu_ctrl
cpu_en  out  1  clock enable to cpu_ctrl, registered
busy  out  1  high in RUN, BURST, STEP
done  out  1  one-cycle pulse at burst completion
cycle_cnt  out  CNT_W  number of cycles cpu_en was high since last start, saturating

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- While rst is high, all outputs are held at reset values:
  - state=S_RST, cpu_rst=1, cpu_en=0, busy=0, done=0, cycle_cnt=0.
  - Internal counters=0; step edge-detect register=0.
- S_RST: cpu_rst=1 for exactly RST_CYCLES rising edges after rst falls, then S_IDLE with cpu_rst=0.
  - start/step/halt are ignored in S_RST.
- S_IDLE: cpu_en=0. If start=1 and halt=0, cycle_cnt clears to 0 and the next state depends on mode:
  - 00 -> S_RUN.
  - 01 -> S_BURST with remaining=burst_len. If burst_len=0, go straight to S_IDLE with done=1 for one cycle and no cpu_en.
  - 10 -> S_STEP.
  - 11 -> stay in S_IDLE; no output change.
- Latency: start sampled at edge k -> cpu_en=1 and busy=1 from edge k+1.
- S_RUN: cpu_en=1 every cycle until halt.
- S_BURST: cpu_en=1 for exactly burst_len consecutive cycles.
  - remaining decrements on each enabled cycle.
  - After the last enabled cycle, cpu_en=0, done=1 for one cycle, state=S_IDLE.
- S_STEP:
  - cpu_en=1 for exactly one cycle per rising edge of step (registered edge detect). A step rising edge sampled at edge k gives cpu_en high for the cycle after edge k+1.
  - Holding step high gives a single pulse.
  - Exit only via halt.
- halt=1 in S_RUN, S_BURST or S_STEP: at the next edge, state=S_IDLE, cpu_en=0, busy=0, done=0.
  - cycle_cnt is retained.
  - halt and the final burst cycle on the same edge: halt wins and done is not asserted.
- cycle_cnt increments on every edge where cpu_en=1. It saturates at 2^CNT_W-1 and does not wrap.
- start is ignored outside S_IDLE; a mode change mid-operation has no effect.
- rst asserted mid-operation: immediate return to S_RST, and the full cpu_rst stretch is reapplied.

Decomposition:
- Package cpu_run_pkg holds:
  - mode encodings (MODE_RUN, MODE_BURST, MODE_STEP, MODE_RSVD);
  - the state encoding (S_RST, S_IDLE, S_RUN, S_BURST, S_STEP);
  - default parameter constants.
- One sub-module, sat_counter: parametrised width, sync clear, increment enable, saturates at all-ones, async active-high reset. It is used for cycle_cnt.
- The reset-stretch and burst counters stay inline.

Test Plan:
- Reset stretch: RST_CYCLES=4, rst high then low -> cpu_rst high for exactly 4 edges after release, then 0. cpu_en=0 throughout; start held high during this window is ignored.
- Burst: mode=01, burst_len=5, start pulse -> cpu_en high exactly 5 cycles starting one edge after start, done pulses one cycle after the last, cycle_cnt=5, busy falls with done.
- Zero burst: mode=01, burst_len=0, start -> no cpu_en, done=1 for one cycle, cycle_cnt=0.
- Step: mode=10, start, then 3 step pulses with step held high 4 cycles each -> exactly 3 single-cycle cpu_en pulses, cycle_cnt=3. Then halt -> S_IDLE, busy=0.
- Halt priority and saturation: CNT_W=4, free-run 20 cycles -> cycle_cnt stops at 15. Then halt asserted with start also high -> cpu_en=0 next edge, stays in IDLE; a later start clears cycle_cnt to 0.
- Mid-run reset: rst asserted asynchronously during S_RUN -> cpu_en=0 and cpu_rst=1 immediately (no clk edge needed), cycle_cnt=0, full stretch reapplied.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared encodings and defaults for the CPU run/step controller.
package cpu_run_pkg;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_BURST_W    = 8;
    localparam int DEF_RST_CYCLES = 4;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_BURST = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_RST,
        S_IDLE,
        S_RUN,
        S_BURST,
        S_STEP
    } state_e;

    function automatic logic is_busy(input state_e s);
        return s inside {S_RUN, S_BURST, S_STEP};
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Harness-facing control/status bundle of the run/step controller.
interface cpu_run_ctrl_if
    import cpu_run_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int BURST_W = DEF_BURST_W
);
    logic [1:0]         mode;
    logic               start;
    logic               step;
    logic               halt;
    logic [BURST_W-1:0] burst_len;
    logic               cpu_rst;
    logic               cpu_en;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cycle_cnt;

    modport master (
        output mode, start, step, halt, burst_len,
        input  cpu_rst, cpu_en, busy, done, cycle_cnt
    );

    modport slave (
        input  mode, start, step, halt, burst_len,
        output cpu_rst, cpu_en, busy, done, cycle_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: stretched CPU reset plus registered clock-enable for
// free-run, N-cycle burst and single-step operation.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int BURST_W    = DEF_BURST_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);
    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e             state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic               cpu_en_q, cpu_en_d;
    logic               done_q, done_d;
    logic               step_q, step_rise_q;
    logic               cnt_clr;
    mode_e              mode;
    logic               start_ok;
    logic               rst_last;
    logic               burst_last;

    assign mode       = mode_e'(bus.mode);
    assign start_ok   = bus.start && !bus.halt;
    assign rst_last   = (rst_cnt_q == RST_W'(RST_CYCLES - 1));
    assign burst_last = (remaining_q == BURST_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   if (rst_last) state_d = S_IDLE;
            S_IDLE: begin
                if (start_ok) begin
                    case (mode)
                        MODE_RUN:   state_d = S_RUN;
                        MODE_BURST: if (bus.burst_len != '0) state_d = S_BURST;
                        MODE_STEP:  state_d = S_STEP;
                        MODE_RSVD:  state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN,
            S_STEP:  if (bus.halt) state_d = S_IDLE;
            S_BURST: if (bus.halt || burst_last) state_d = S_IDLE;
            default: state_d = S_RST;
        endcase
    end

    // Next values of the registered outputs and the inline counters.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        cpu_en_d    = 1'b0;
        done_d      = 1'b0;
        cnt_clr     = 1'b0;
        remaining_d = remaining_q;
        rst_cnt_d   = rst_cnt_q;
        case (state_q)
            S_RST: rst_cnt_d = rst_last ? '0 : rst_cnt_q + RST_W'(1);
            S_IDLE: begin
                if (start_ok && mode != MODE_RSVD) begin
                    cnt_clr = 1'b1;
                    if (mode == MODE_RUN) begin
                        cpu_en_d = 1'b1;
                    end else if (mode == MODE_BURST) begin
                        if (bus.burst_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            cpu_en_d    = 1'b1;
                            remaining_d = bus.burst_len;
                        end
                    end
                end
            end
            S_RUN: cpu_en_d = !bus.halt;
            S_BURST: begin
                if (bus.halt) begin
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - BURST_W'(1);
                    done_d      = burst_last;
                    cpu_en_d    = !burst_last;
                end
            end
            S_STEP: cpu_en_d = !bus.halt && step_rise_q;
            default: ;
        endcase
    end

    // The step edge is registered once more so the enable lands one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_q   <= '0;
            remaining_q <= '0;
            cpu_en_q    <= 1'b0;
            done_q      <= 1'b0;
            step_q      <= 1'b0;
            step_rise_q <= 1'b0;
        end else begin
            rst_cnt_q   <= rst_cnt_d;
            remaining_q <= remaining_d;
            cpu_en_q    <= cpu_en_d;
            done_q      <= done_d;
            step_q      <= bus.step;
            step_rise_q <= bus.step && !step_q;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cpu_en_q),
        .cnt (bus.cycle_cnt)
    );

    assign bus.cpu_rst = (state_q == S_RST);
    assign bus.cpu_en  = cpu_en_q;
    assign bus.busy    = is_busy(state_q);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_cpu_run_ctrl;
    localparam int CNT_W      = 4;
    localparam int BURST_W    = 8;
    localparam int RST_CYCLES = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    localparam int A_NONE  = 0;
    localparam int A_RUN   = 1;
    localparam int A_BURST = 2;
    localparam int A_STEP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model state
    int m_rst_left = RST_CYCLES;
    int m_act      = A_NONE;
    int m_owed     = 0;
    int m_en       = 0;
    int m_done     = 0;
    int m_cnt      = 0;
    int s_last     = 0;
    int s_pend     = 0;
    int in_mode, in_len, in_start, in_halt, in_step, prev_en;

    cpu_run_ctrl_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

    cpu_run_ctrl #(
        .CNT_W      (CNT_W),
        .BURST_W    (BURST_W),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: one update per clock edge, reset immediately on rst.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_rst_left = RST_CYCLES;
            m_act = A_NONE; m_owed = 0; m_en = 0; m_done = 0; m_cnt = 0;
            s_last = 0; s_pend = 0;
        end else begin
            in_mode  = int'(bus.mode);
            in_len   = int'(bus.burst_len);
            in_start = int'(bus.start);
            in_halt  = int'(bus.halt);
            in_step  = int'(bus.step);
            prev_en  = m_en;
            if (prev_en != 0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_en = 0;
            m_done = 0;
            if (m_rst_left > 0) begin
                m_rst_left = m_rst_left - 1;
            end else if (m_act == A_NONE) begin
                if (in_start != 0 && in_halt == 0 && in_mode != 3) begin
                    m_cnt = 0;
                    if (in_mode == 0) begin
                        m_act = A_RUN; m_en = 1;
                    end else if (in_mode == 1) begin
                        if (in_len == 0) m_done = 1;
                        else begin m_act = A_BURST; m_owed = in_len - 1; m_en = 1; end
                    end else begin
                        m_act = A_STEP;
                    end
                end
            end else if (in_halt != 0) begin
                m_act = A_NONE;
            end else if (m_act == A_RUN) begin
                m_en = 1;
            end else if (m_act == A_BURST) begin
                if (m_owed > 0) begin m_en = 1; m_owed = m_owed - 1; end
                else begin m_done = 1; m_act = A_NONE; end
            end else begin
                m_en = s_pend;
            end
            s_pend = (in_step != 0 && s_last == 0) ? 1 : 0;
            s_last = in_step;
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        check("cpu_rst",   bus.cpu_rst,   (m_rst_left > 0) ? 1 : 0);
        check("cpu_en",    bus.cpu_en,    m_en);
        check("busy",      bus.busy,      (m_act != A_NONE) ? 1 : 0);
        check("done",      bus.done,      m_done);
        check("cycle_cnt", bus.cycle_cnt, m_cnt);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, en_seen, done_seen;
        bus.mode = 2'b00; bus.start = 1'b1; bus.step = 1'b0;
        bus.halt = 1'b0;  bus.burst_len = '0;

        // Reset values, with start held high through the stretch
        repeat (3) tick();
        check("rst_cpu_rst", bus.cpu_rst, 1);
        check("rst_cpu_en",  bus.cpu_en, 0);
        check("rst_busy",    bus.busy, 0);
        check("rst_done",    bus.done, 0);
        check("rst_cnt",     bus.cycle_cnt, 0);
        rst = 1'b0;
        n = 0;
        while (bus.cpu_rst && n < 10) begin
            tick();
            n++;
            check("stretch_en", bus.cpu_en, 0);
        end
        check("stretch_edges", n, 4);
        bus.start = 1'b0;
        tick();
        check("idle_busy", bus.busy, 0);

        // Burst of 5
        bus.mode = 2'b01; bus.burst_len = 8'd5; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("burst_latency", bus.cpu_en, 1);
        en_seen = 0; done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.cpu_en) en_seen++;
            if (bus.done) begin
                done_seen++;
                check("burst_busy_at_done", bus.busy, 0);
                check("burst_cnt", bus.cycle_cnt, 5);
            end
            tick();
        end
        check("burst_en_cycles", en_seen, 5);
        check("burst_done_pulses", done_seen, 1);

        // Zero-length burst
        bus.burst_len = 8'd0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("zburst_done", bus.done, 1);
        check("zburst_en",   bus.cpu_en, 0);
        check("zburst_cnt",  bus.cycle_cnt, 0);
        tick();
        check("zburst_done_clr", bus.done, 0);

        // Single step: three long step pulses
        bus.mode = 2'b10; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("step_busy", bus.busy, 1);
        en_seen = 0;
        for (int p = 0; p < 3; p++) begin
            bus.step = 1'b1;
            repeat (4) begin tick(); if (bus.cpu_en) en_seen++; end
            bus.step = 1'b0;
            repeat (2) begin tick(); if (bus.cpu_en) en_seen++; end
        end
        check("step_pulses", en_seen, 3);
        check("step_cnt", bus.cycle_cnt, 3);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("step_halt_busy", bus.busy, 0);

        // Free run into saturation, then halt with start also high
        bus.mode = 2'b00; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        check("sat_cnt", bus.cycle_cnt, 15);
        bus.halt = 1'b1; bus.start = 1'b1;
        tick();
        check("halt_en", bus.cpu_en, 0);
        check("halt_busy", bus.busy, 0);
        check("halt_cnt_kept", bus.cycle_cnt, 15);
        tick();
        check("halt_stays_idle", bus.busy, 0);
        bus.halt = 1'b0;
        tick();
        bus.start = 1'b0;
        check("restart_cnt", bus.cycle_cnt, 0);
        check("restart_en", bus.cpu_en, 1);

        // Asynchronous reset while running
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("async_en", bus.cpu_en, 0);
        check("async_cpu_rst", bus.cpu_rst, 1);
        check("async_cnt", bus.cycle_cnt, 0);
        check("async_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bus.cpu_rst && n < 10) begin tick(); n++; end
        check("restretch_edges", n, 4);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            bus.mode      = 2'($urandom);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.halt      = ($urandom_range(0, 15) == 0);
            bus.burst_len = 8'($urandom_range(0, 12));
            if ($urandom_range(0, 2) == 0) bus.step = !bus.step;
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            tick();
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
